// File: rtl/spi_slave_pkg.sv
// Shared types and default sizes for the SPI mode-0 responder.
package spi_slave_pkg;

   localparam int DATA_W_DEF      = 8;
   localparam int SYNC_STAGES_DEF = 2;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/spi_slave_resp_sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous pin with registered-edge rise/fall pulses.
// primed goes high once every flop in the chain holds a post-reset sample of the pin.
module sync_edge_det
   import spi_slave_pkg::*;
#(
   parameter int   STAGES    = SYNC_STAGES_DEF,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall,
   output logic primed
);

   logic [STAGES-1:0] sync_r;
   logic              prev_r;
   logic [STAGES:0]   fill_r;

   // Synchroniser chain, edge-detect flop and post-reset fill tracker
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_r <= {STAGES{RESET_VAL}};
         prev_r <= RESET_VAL;
         fill_r <= {(STAGES + 1){1'b0}};
      end else begin
         sync_r <= {sync_r[STAGES-2:0], async_in};
         prev_r <= sync_r[STAGES-1];
         fill_r <= {fill_r[STAGES-1:0], 1'b1};
      end
   end

   assign level  = sync_r[STAGES-1];
   assign rise   = sync_r[STAGES-1] & ~prev_r;
   assign fall   = ~sync_r[STAGES-1] & prev_r;
   assign primed = fill_r[STAGES];

endmodule

// File: rtl/spi_slave_resp.sv
// SPI mode-0 responder: oversampled pins, MSB-first receive/transmit, one-deep transmit buffer.
// Optional feature macro: SPI_SLAVE_LOOPBACK_EN (adds loopback_test, echoing received bytes).
module spi_slave_resp
   import spi_slave_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic              clk_int,
   input  logic              reset,
   input  logic              sclk,
   input  logic              cs_bar,
   input  logic              din_mosi,
   output logic              dout_miso,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_load,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              tx_underrun,
   output logic              busy
`ifdef SPI_SLAVE_LOOPBACK_EN
   ,
   input  logic              loopback_test
`endif
);

   localparam int               CNT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic sclk_rise_s, sclk_fall_s, unused_sclk_level_s, unused_sclk_primed_s;
   logic cs_level_s, cs_rise_s, cs_fall_s, cs_primed_s;
   logic [SYNC_STAGES-1:0] mosi_sync_r;
   logic mosi_s;

   state_t            state_r;
   logic              armed_r;
   logic [CNT_W-1:0]  bit_cnt_r;
   logic [DATA_W-1:0] rx_shift_r;
   logic [DATA_W-1:0] tx_shift_r;
   logic [DATA_W-1:0] buf_r;

   logic              cs_act_s;
   logic              rx_done_s;
   logic              reload_s;
   logic              load_acc_s;
   logic              underrun_s;
   logic [DATA_W-1:0] rx_byte_s;
   logic [DATA_W-1:0] next_tx_s;

   sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
      .clk      (clk_int),
      .reset    (reset),
      .async_in (sclk),
      .level    (unused_sclk_level_s),
      .rise     (sclk_rise_s),
      .fall     (sclk_fall_s),
      .primed   (unused_sclk_primed_s)
   );

   sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
      .clk      (clk_int),
      .reset    (reset),
      .async_in (cs_bar),
      .level    (cs_level_s),
      .rise     (cs_rise_s),
      .fall     (cs_fall_s),
      .primed   (cs_primed_s)
   );

   // MOSI level synchroniser, same depth as sclk so the sample lines up with its rise pulse
   always_ff @(posedge clk_int) begin
      if (reset) begin
         mosi_sync_r <= {SYNC_STAGES{1'b0}};
      end else begin
         mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], din_mosi};
      end
   end

   assign mosi_s = mosi_sync_r[SYNC_STAGES-1];

   // Per-cycle decode of pin events, buffer acceptance and the next transmit byte
   always_comb begin
      cs_act_s   = cs_fall_s & armed_r;
      rx_byte_s  = {rx_shift_r[DATA_W-2:0], mosi_s};
      rx_done_s  = 1'b0;
      reload_s   = 1'b0;
      next_tx_s  = {DATA_W{1'b0}};
      underrun_s = 1'b0;
`ifdef SPI_SLAVE_LOOPBACK_EN
      load_acc_s = tx_load & tx_ready & ~loopback_test;
`else
      load_acc_s = tx_load & tx_ready;
`endif
      case (state_r)
         IDLE: begin
            reload_s = cs_act_s;
         end
         SHIFT: begin
            if (!cs_rise_s) begin
               rx_done_s = sclk_rise_s & (bit_cnt_r == CNT_LAST);
               reload_s  = sclk_fall_s & (bit_cnt_r == CNT_ZERO);
            end else begin
               rx_done_s = 1'b0;
               reload_s  = 1'b0;
            end
         end
         default: begin
            reload_s = 1'b0;
         end
      endcase
      // An empty buffer with a same-cycle load bypasses straight into the shifter
      if (!tx_ready) begin
         next_tx_s = buf_r;
      end else if (load_acc_s) begin
         next_tx_s = tx_data;
      end else begin
         underrun_s = 1'b1;
      end
   end

   // Transmit buffer, frame FSM and all registered outputs
   always_ff @(posedge clk_int) begin
      if (reset) begin
         state_r     <= IDLE;
         armed_r     <= 1'b0;
         bit_cnt_r   <= CNT_ZERO;
         rx_shift_r  <= {DATA_W{1'b0}};
         tx_shift_r  <= {DATA_W{1'b0}};
         buf_r       <= {DATA_W{1'b0}};
         tx_ready    <= 1'b1;
         rx_data     <= {DATA_W{1'b0}};
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
         busy        <= 1'b0;
         dout_miso   <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         armed_r  <= armed_r | (cs_level_s & cs_primed_s);

         if (reload_s && !tx_ready) begin
            tx_ready <= 1'b1;
         end else if (load_acc_s && !reload_s) begin
            buf_r    <= tx_data;
            tx_ready <= 1'b0;
`ifdef SPI_SLAVE_LOOPBACK_EN
         end else if (loopback_test && rx_done_s) begin
            buf_r    <= rx_byte_s;
            tx_ready <= 1'b0;
`endif
         end else begin
            tx_ready <= tx_ready;
         end

         case (state_r)
            IDLE: begin
               busy      <= 1'b0;
               dout_miso <= 1'b0;
               if (cs_act_s) begin
                  state_r     <= SHIFT;
                  busy        <= 1'b1;
                  bit_cnt_r   <= CNT_ZERO;
                  tx_shift_r  <= next_tx_s;
                  dout_miso   <= next_tx_s[DATA_W-1];
                  tx_underrun <= underrun_s;
               end
            end
            SHIFT: begin
               if (cs_rise_s) begin
                  state_r   <= IDLE;
                  busy      <= 1'b0;
                  dout_miso <= 1'b0;
                  bit_cnt_r <= CNT_ZERO;
               end else if (sclk_rise_s) begin
                  rx_shift_r <= rx_byte_s;
                  if (rx_done_s) begin
                     rx_data   <= rx_byte_s;
                     rx_valid  <= 1'b1;
                     bit_cnt_r <= CNT_ZERO;
                  end else begin
                     bit_cnt_r <= bit_cnt_r + CNT_ONE;
                  end
               end else if (reload_s) begin
                  tx_shift_r  <= next_tx_s;
                  dout_miso   <= next_tx_s[DATA_W-1];
                  tx_underrun <= tx_underrun | underrun_s;
               end else if (sclk_fall_s) begin
                  tx_shift_r <= {tx_shift_r[DATA_W-2:0], 1'b0};
                  dout_miso  <= tx_shift_r[DATA_W-2];
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/spi_slave_resp.md
# spi_slave_resp

SPI mode-0 responder (slave) that is the far end of the SPI master in the multiplier communication block. It oversamples `sclk`, `cs_bar` and `din_mosi` on the system clock, deserialises MSB-first bytes onto a valid-pulse interface, and serialises bytes from a one-deep transmit buffer onto `dout_miso`. It sits between the SPI pins and the multiplier datapath, so the multiplier can be driven by an external SPI master.

## Interface
- `DATA_W`, 8: bits per SPI word.
- `SYNC_STAGES`, 2: flops in each input synchroniser, minimum 2.
- `clk_int` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `sclk` in 1: SPI clock from the master; asynchronous to `clk_int`.
- `cs_bar` in 1: active-low chip select; asynchronous.
- `din_mosi` in 1: serial data from the master.
- `dout_miso` out 1: serial data to the master; driven 0 while deselected.
- `tx_data` in DATA_W: next byte to send.
- `tx_load` in 1: write strobe for `tx_data`; accepted only when `tx_ready`=1.
- `tx_ready` out 1: transmit buffer empty.
- `rx_data` out DATA_W: last complete received byte; holds its value until the next byte completes.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `tx_underrun` out 1: sticky; a byte boundary found the transmit buffer empty.
- `busy` out 1: high in SHIFT.

## Operation
- Reset values:
  - `dout_miso`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `tx_underrun`=0, `busy`=0.
  - Synchronisers reset to `cs_bar`=1, `sclk`=0; state IDLE; buffer empty; `armed`=0.
- `armed`:
  - Set once the synchronised `cs_bar` is seen high.
  - A falling edge of `cs_bar` is acted on only when `armed`=1. A select held low through reset is therefore ignored until it deasserts.
- IDLE -> SHIFT on a synchronised `cs_bar` falling edge:
  - Bit counter cleared; `tx_underrun` cleared.
  - Transmit shift register loaded from the buffer, or with 0x00 and `tx_underrun`=1 if the buffer is empty.
  - `dout_miso` = shift register MSB.
- SHIFT, `sclk` rising edge: shift `din_mosi` into the receive register and increment the bit counter.
  - On the DATA_W-th rising edge: `rx_data` takes the assembled byte, `rx_valid` pulses, and the counter wraps to 0.
- SHIFT, `sclk` falling edge:
  - Counter ≠ 0: shift the transmit register left.
  - Counter = 0 (byte boundary): reload from the buffer. If the buffer is empty, load 0x00 and set `tx_underrun`.
- SHIFT -> IDLE on a synchronised `cs_bar` rising edge:
  - A partial receive byte is discarded with no `rx_valid`.
  - The buffer contents are kept; `dout_miso` goes to 0.
- `tx_load` with `tx_ready`=0 is ignored; the buffer is never overwritten.
- `tx_load` in the same cycle as a reload with an empty buffer bypasses: `tx_data` goes straight into the shift register, the buffer stays empty, and there is no underrun.
- `reset` during SHIFT aborts immediately and emits no `rx_valid`.

## Timing
- Input path is `SYNC_STAGES` flops plus one edge-detect flop. `rx_valid` rises `SYNC_STAGES`+1 `clk_int` cycles after the DATA_W-th `sclk` rising edge at the pin.
- Requirements on the master:
  - `sclk` frequency ≤ `clk_int`/8.
  - `cs_bar` fall to first `sclk` rise ≥ `SYNC_STAGES`+2 `clk_int` cycles.
- `dout_miso` changes `SYNC_STAGES`+1 cycles after an `sclk` falling edge. It must be stable before the next rising edge, which the `sclk` limit guarantees.
- `tx_ready` falls the cycle after an accepted `tx_load`. It rises the cycle after the buffer is consumed at a byte boundary.

## Configuration
- `SPI_SLAVE_LOOPBACK_EN`
  - Defined: adds input port `loopback_test`. When it is 1, each completed receive byte is written into the transmit buffer in the `rx_valid` cycle, and `tx_load` is ignored. The master therefore reads back byte N during byte N+1.
  - Undefined: no port and no loopback logic.

## Structure
- `spi_slave_pkg`: state enum (IDLE, SHIFT) and the `DATA_W` default constant.
- Sub-module `sync_edge_det`: parameterised synchroniser with rise/fall pulse outputs. Instantiated for `sclk` and `cs_bar`; `din_mosi` uses its synchronised level only.

## Test plan
- Preload 0xA5, select, clock 8 bits with MOSI=0x3C at `sclk`=`clk_int`/8 -> `rx_data`=0x3C with a single `rx_valid` pulse; MISO bits read 1,0,1,0,0,1,0,1; `tx_underrun`=0.
- Two-byte frame, load 0x12 then 0x34 on `tx_ready` -> master reads 0x12,0x34; two `rx_valid` pulses.
- No preload -> MISO reads 0x00 and `tx_underrun`=1; it clears at the next `cs_bar` fall.
- Deselect after 5 bits -> no `rx_valid`, state IDLE, `busy`=0; the next full frame receives correctly.
- Assert `reset` mid-byte while `cs_bar` stays low -> all outputs at reset values; no activity until `cs_bar` goes high then low again.
- With `SPI_SLAVE_LOOPBACK_EN` and `loopback_test`=1, send 0x55,0xAA,0x0F -> MISO returns 0x00,0x55,0xAA.
